// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the 8-channel round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned NCH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [2:0] onehot8_to_idx(input logic [NCH-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit after ptr, with ptr itself checked last.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [2:0]     ptr,
    output logic           any,
    output logic [2:0]     idx
);

    logic       found;
    logic [2:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        // i = 8 wraps back to ptr, so the last-granted channel has lowest priority
        for (int i = 1; i <= NCH; i++) begin
            cand = ptr + i[2:0];
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// 8:1 one-bit mux shared by 8 requesters under round-robin arbitration with a burst limit.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CW        = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] din,
    output logic [NCH-1:0] gnt,
    output logic [2:0]     sel,
    output logic           o,
    output logic           o_valid,
    output logic [2:0]     o_src,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [2:0]     sel_q, sel_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           o_q, o_d;
    logic           o_valid_q, o_valid_d;
    logic [2:0]     o_src_q, o_src_d;

    logic           pick_any;
    logic [2:0]     pick_idx;
    logic [2:0]     pick_ptr;
    logic           xfer;
    logic           dsel;
    logic [CW-1:0]  cnt_inc;
    logic [NCH-1:0] pick_oh;

    // While granted, the release pick rotates from the current channel, which becomes the new ptr
    assign pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign xfer    = req[sel_q];
    assign dsel    = din[sel_q];
    assign cnt_inc = cnt_q + CW'(1);
    assign pick_oh = 8'b1 << pick_idx;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_valid_d = 1'b0;
        o_src_d   = o_src_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_oh;
                    sel_d   = onehot8_to_idx(pick_oh);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d     = cnt_inc;
                    o_d       = dsel;
                    o_valid_d = 1'b1;
                    o_src_d   = sel_q;
                end
                if (!xfer || (cnt_inc == CW'(MAX_BURST))) begin
                    ptr_d = sel_q;
                    cnt_d = '0;
                    if (pick_any) begin
                        gnt_d = pick_oh;
                        sel_d = onehot8_to_idx(pick_oh);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= 3'd7;
            cnt_q     <= '0;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            o_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            o_src_q   <= o_src_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign o_src   = o_src_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (MAX_BURST = 4).
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       o;
    logic       o_valid;
    logic [2:0] o_src;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    mux8_rr_arbiter #(
        .MAX_BURST (4),
        .CW        (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .o       (o),
        .o_valid (o_valid),
        .o_src   (o_src),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        din   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h want 00", gnt); end
        n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", sel); end
        n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL reset_o got %b want 0", o); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid got %b want 0", o_valid); end
        n_cmp++; if (o_src !== 3'd0) begin n_err++; $display("FAIL reset_osrc got %0d want 0", o_src); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (dut.ptr_q !== 3'd7) begin n_err++; $display("FAIL reset_ptr got %0d want 7", dut.ptr_q); end
        n_cmp++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
    endtask

    // Lone requester ch3: continuous grant, counter wraps every 4 transfers
    task automatic test_lone_burst();
        do_reset();
        req = 8'h08;
        din = 8'h08;
        for (int k = 0; k < 13; k++) begin
            step();
            n_cmp++; if (gnt !== 8'h08) begin n_err++; $display("FAIL lone_gnt k=%0d got %h want 08", k, gnt); end
            n_cmp++; if (sel !== 3'd3) begin n_err++; $display("FAIL lone_sel k=%0d got %0d want 3", k, sel); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lone_busy k=%0d got %b want 1", k, busy); end
            n_cmp++;
            if (dut.cnt_q !== 4'(k % 4)) begin
                n_err++; $display("FAIL lone_cnt k=%0d got %0d want %0d", k, dut.cnt_q, k % 4);
            end
            n_cmp++;
            if (o_valid !== (k >= 1)) begin
                n_err++; $display("FAIL lone_ovalid k=%0d got %b want %b", k, o_valid, k >= 1);
            end
            if (k >= 1) begin
                n_cmp++; if (o_src !== 3'd3) begin n_err++; $display("FAIL lone_osrc k=%0d got %0d want 3", k, o_src); end
                n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL lone_o k=%0d got %b want 1", k, o); end
            end
        end
    endtask

    // All requesting: 0..7,0 with 4 cycles each and no gaps
    task automatic test_full_rotation();
        logic [7:0] applied;
        int         ch;
        int         src;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 37; k++) begin
            din     = 8'($urandom);
            applied = din;
            step();
            ch = (k / 4) % 8;
            n_cmp++;
            if (gnt !== (8'h01 << ch)) begin
                n_err++; $display("FAIL rot_gnt k=%0d got %h want %h", k, gnt, 8'h01 << ch);
            end
            n_cmp++; if (sel !== 3'(ch)) begin n_err++; $display("FAIL rot_sel k=%0d got %0d want %0d", k, sel, ch); end
            if (k >= 1) begin
                src = ((k - 1) / 4) % 8;
                n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rot_ovalid k=%0d got %b want 1", k, o_valid); end
                n_cmp++;
                if (o_src !== 3'(src)) begin
                    n_err++; $display("FAIL rot_osrc k=%0d got %0d want %0d", k, o_src, src);
                end
                n_cmp++;
                if (o !== applied[src]) begin
                    n_err++; $display("FAIL rot_o k=%0d got %b want %b", k, o, applied[src]);
                end
            end
        end
    endtask

    // ch0/ch7 alternate; dropping req[7] mid-burst releases to ch0
    task automatic test_two_req();
        logic [7:0] want;
        do_reset();
        req = 8'h81;
        din = 8'h00;
        for (int k = 0; k < 14; k++) begin
            step();
            want = ((k / 4) % 2 == 0) ? 8'h01 : 8'h80;
            n_cmp++; if (gnt !== want) begin n_err++; $display("FAIL two_gnt k=%0d got %h want %h", k, gnt, want); end
        end
        // now ch7 has made one transfer
        req = 8'h01;
        step();
        n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL drop_gnt got %h want 01", gnt); end
        n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL drop_sel got %0d want 0", sel); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL drop_ovalid got %b want 0", o_valid); end
        n_cmp++; if (dut.ptr_q !== 3'd7) begin n_err++; $display("FAIL drop_ptr got %0d want 7", dut.ptr_q); end
    endtask

    // Short burst then idle; ptr remembers ch2 so ch0 wins over ch2 next
    task automatic test_drop_to_idle();
        do_reset();
        req = 8'h04;
        din = 8'h04;
        step();
        n_cmp++; if (gnt !== 8'h04) begin n_err++; $display("FAIL idle_first_gnt got %h want 04", gnt); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL idle_first_ovalid got %b want 0", o_valid); end
        step();
        step();
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL idle_xfer_ovalid got %b want 1", o_valid); end
        n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL idle_xfer_o got %b want 1", o); end
        req = 8'h00;
        step();
        n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL idle_gnt got %h want 00", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL idle_ovalid got %b want 0", o_valid); end
        n_cmp++; if (sel !== 3'd2) begin n_err++; $display("FAIL idle_sel got %0d want 2", sel); end
        n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL idle_o_hold got %b want 1", o); end
        n_cmp++; if (dut.ptr_q !== 3'd2) begin n_err++; $display("FAIL idle_ptr got %0d want 2", dut.ptr_q); end
        step();
        n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL idle_stay_gnt got %h want 00", gnt); end
        req = 8'h05;
        step();
        n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL idle_regrant_gnt got %h want 01", gnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL idle_regrant_busy got %b want 1", busy); end
    endtask

    // Asynchronous reset in the 3rd cycle of a ch5 burst
    task automatic test_async_reset();
        do_reset();
        req = 8'h20;
        din = 8'h20;
        step();
        step();
        step();
        n_cmp++; if (gnt !== 8'h20) begin n_err++; $display("FAIL ares_pre_gnt got %h want 20", gnt); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ares_pre_ovalid got %b want 1", o_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL ares_gnt got %h want 00", gnt); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ares_ovalid got %b want 0", o_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ares_busy got %b want 0", busy); end
        n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL ares_sel got %0d want 0", sel); end
        n_cmp++; if (o_src !== 3'd0) begin n_err++; $display("FAIL ares_osrc got %0d want 0", o_src); end
        n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL ares_o got %b want 0", o); end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        step();
        n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL ares_after_gnt got %h want 01", gnt); end
        n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL ares_after_sel got %0d want 0", sel); end
    endtask

    // Granted channel's din toggles, all others opposite: o must follow ch5 only
    task automatic test_din_pattern();
        logic ph;
        do_reset();
        req = 8'h20;
        for (int k = 0; k < 12; k++) begin
            ph  = ((k % 3) == 0) || (k == 7);
            din = ph ? 8'h20 : 8'hDF;
            step();
            if (k >= 1) begin
                n_cmp++; if (o !== ph) begin n_err++; $display("FAIL pat_o k=%0d got %b want %b", k, o, ph); end
                n_cmp++; if (o_src !== 3'd5) begin n_err++; $display("FAIL pat_osrc k=%0d got %0d want 5", k, o_src); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        din   = '0;
        test_reset();
        test_lone_burst();
        test_full_rotation();
        test_two_req();
        test_drop_to_idle();
        test_async_reset();
        test_din_pattern();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
